// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: FSM encoding and port ids.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

endpackage : sram_arbiter_pkg

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Two-way round-robin select: on a tie the port that did not win last time is chosen.
module rr_arbiter2
  import sram_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
      grant_o = (last_grant_i == PORT_AUX) ? 2'b01 : 2'b10;
    end else begin
      grant_o = valid_i;
    end
  end

endmodule : rr_arbiter2

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between the CPU (port 0) and an auxiliary master (port 1),
// one transaction at a time, with round-robin fairness on contention.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p0_valid,
  input  logic                  p0_we_n,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ready,
  output logic                  p0_rsp_valid,
  output logic [DATA_WIDTH-1:0] p0_rdata,

  input  logic                  p1_valid,
  input  logic                  p1_we_n,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ready,
  output logic                  p1_rsp_valid,
  output logic [DATA_WIDTH-1:0] p1_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we_n,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                state_q;
  logic                  owner_q;
  logic                  last_grant_q;
  logic                  is_read_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_n_q;
  logic                  p0_rsp_q, p1_rsp_q;
  logic [DATA_WIDTH-1:0] p0_rdata_q, p1_rdata_q;
  logic [DATA_WIDTH-1:0] p0_rdata_d, p1_rdata_d;

  logic [1:0] grant;
  logic       can_grant;
  logic       winner;

  rr_arbiter2 u_rr (
    .valid_i      ({p1_valid, p0_valid}),
    .last_grant_i (last_grant_q),
    .grant_o      (grant)
  );

  assign can_grant = (state_q != ST_ISSUE) && (grant != 2'b00);
  assign winner    = grant[1] ? PORT_AUX : PORT_CPU;
  assign p0_ready  = can_grant & grant[0];
  assign p1_ready  = can_grant & grant[1];

  // The SRAM read data only exists in the response cycle, so it is forwarded
  // straight through then and latched to hold until that port's next response.
  assign p0_rdata_d = (p0_rsp_q && is_read_q) ? mem_rdata : p0_rdata_q;
  assign p1_rdata_d = (p1_rsp_q && is_read_q) ? mem_rdata : p1_rdata_q;

  assign p0_rdata     = p0_rdata_d;
  assign p1_rdata     = p1_rdata_d;
  assign p0_rsp_valid = p0_rsp_q;
  assign p1_rsp_valid = p1_rsp_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we_n     = mem_we_n_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_CPU;
      last_grant_q <= PORT_AUX;
      is_read_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_n_q   <= 1'b1;
      p0_rsp_q     <= 1'b0;
      p1_rsp_q     <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
    end else begin
      p0_rsp_q   <= 1'b0;
      p1_rsp_q   <= 1'b0;
      mem_we_n_q <= 1'b1;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      unique case (state_q)
        ST_IDLE, ST_RESP: begin
          if (can_grant) begin
            state_q      <= ST_ISSUE;
            owner_q      <= winner;
            last_grant_q <= winner;
            mem_addr_q   <= (winner == PORT_AUX) ? p1_addr  : p0_addr;
            mem_wdata_q  <= (winner == PORT_AUX) ? p1_wdata : p0_wdata;
            mem_we_n_q   <= (winner == PORT_AUX) ? p1_we_n  : p0_we_n;
            is_read_q    <= (winner == PORT_AUX) ? p1_we_n  : p0_we_n;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          state_q  <= ST_RESP;
          p0_rsp_q <= (owner_q == PORT_CPU);
          p1_rsp_q <= (owner_q == PORT_AUX);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a registered-read SRAM model behind it.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_valid, p0_we_n, p1_valid, p1_we_n;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ready, p0_rsp_valid, p1_ready, p1_rsp_valid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we_n;

  int total = 0;
  int bad   = 0;

  // Unwritten locations read back as the inverted address.
  bit [15:0] sram    [0:65535];
  bit        written [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!mem_we_n) begin
      sram[mem_addr]    <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
    mem_rdata <= written[mem_addr] ? sram[mem_addr] : ~mem_addr;
  end

  sram_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .p0_valid     (p0_valid),
    .p0_we_n      (p0_we_n),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_ready     (p0_ready),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rdata     (p0_rdata),
    .p1_valid     (p1_valid),
    .p1_we_n      (p1_we_n),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_ready     (p1_ready),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rdata     (p1_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we_n     (mem_we_n),
    .mem_rdata    (mem_rdata)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_all();
    p0_valid = 1'b0; p0_we_n = 1'b1; p0_addr = '0; p0_wdata = '0;
    p1_valid = 1'b0; p1_we_n = 1'b1; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic do_reset();
    drop_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    int viol;
    drop_all();
    reset = 1'b1;
    #3;
    total++;
    if ({mem_we_n, mem_addr, mem_wdata} !== {1'b1, 16'h0, 16'h0}) begin
      bad++;
      $display("FAIL reset_mem: we_n/addr/wdata=%b/%h/%h required 1/0000/0000", mem_we_n, mem_addr, mem_wdata);
    end
    total++;
    if ({p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rdata, p1_rdata} !== 36'h0) begin
      bad++;
      $display("FAIL reset_ports: rdy=%b%b rsp=%b%b rdata=%h/%h required all zero",
               p0_ready, p1_ready, p0_rsp_valid, p1_rsp_valid, p0_rdata, p1_rdata);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_we_n !== 1'b1 || p0_ready !== 1'b0 || p1_ready !== 1'b0 ||
          p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++;
      $display("FAIL idle_quiet: %0d active cycles required 0", viol);
    end
    next_cycle();
  endtask

  task automatic test_write_read();
    p0_valid = 1'b1; p0_we_n = 1'b0; p0_addr = 16'd300; p0_wdata = 16'h00A5;
    @(negedge clk);
    total++;
    if ({p0_ready, p1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL wr_grant: p0/p1 ready=%b%b required 10", p0_ready, p1_ready);
    end
    next_cycle();
    p0_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_we_n, mem_addr, mem_wdata, p0_ready} !== {1'b0, 16'd300, 16'h00A5, 1'b0}) begin
      bad++;
      $display("FAIL wr_issue: we_n=%b addr=%0d wdata=%h ready=%b required 0/300/00a5/0",
               mem_we_n, mem_addr, mem_wdata, p0_ready);
    end
    next_cycle();
    p0_valid = 1'b1; p0_we_n = 1'b1; p0_addr = 16'd300; p0_wdata = 16'h0;
    @(negedge clk);
    total++;
    if ({p0_rsp_valid, mem_we_n, p0_ready, p1_rsp_valid} !== 4'b1110) begin
      bad++;
      $display("FAIL wr_resp: rsp/we_n/ready/p1rsp=%b%b%b%b required 1110",
               p0_rsp_valid, mem_we_n, p0_ready, p1_rsp_valid);
    end
    next_cycle();
    p0_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_we_n, p0_rsp_valid} !== 2'b10) begin
      bad++;
      $display("FAIL rd_issue: we_n/rsp=%b%b required 10", mem_we_n, p0_rsp_valid);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (p0_rsp_valid !== 1'b1 || p0_rdata !== 16'h00A5) begin
      bad++;
      $display("FAIL rd_resp: rsp=%b rdata=%h required 1/00a5", p0_rsp_valid, p0_rdata);
    end
    next_cycle();
    @(negedge clk);
    total++;
    if (p0_rsp_valid !== 1'b0 || p0_rdata !== 16'h00A5) begin
      bad++;
      $display("FAIL rd_hold: rsp=%b rdata=%h required 0/00a5", p0_rsp_valid, p0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_both_ports();
    logic [1:0] exp_rdy [0:8];
    logic [1:0] exp_rsp [0:8];
    exp_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    exp_rsp = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    p0_valid = 1'b1; p0_we_n = 1'b1; p0_addr = 16'd100;
    p1_valid = 1'b1; p1_we_n = 1'b0; p1_addr = 16'd100; p1_wdata = 16'h1234;
    for (int c = 0; c <= 8; c++) begin
      if (c == 8) drop_all();
      @(negedge clk);
      total++;
      if ({p1_ready, p0_ready} !== exp_rdy[c]) begin
        bad++;
        $display("FAIL both_ready c%0d: p1p0=%b required %b", c, {p1_ready, p0_ready}, exp_rdy[c]);
      end
      total++;
      if ({p1_rsp_valid, p0_rsp_valid} !== exp_rsp[c]) begin
        bad++;
        $display("FAIL both_rsp c%0d: p1p0=%b required %b", c, {p1_rsp_valid, p0_rsp_valid}, exp_rsp[c]);
      end
      if (c == 2) begin
        total++;
        if (p0_rdata !== 16'hFF9B) begin
          bad++;
          $display("FAIL both_old_data: rdata=%h required ff9b", p0_rdata);
        end
      end
      if (c == 6) begin
        total++;
        if (p0_rdata !== 16'h1234) begin
          bad++;
          $display("FAIL both_new_data: rdata=%h required 1234", p0_rdata);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stream();
    int idx, cyc, gi, rsp_cnt, low_cnt;
    int grant_cyc [0:7];
    bit granted;
    drop_all();
    idx = 0; cyc = 0; gi = 0; rsp_cnt = 0; low_cnt = 0;
    p1_valid = 1'b1; p1_we_n = 1'b0; p1_addr = 16'd200; p1_wdata = 16'd200;
    while (cyc < 40 && rsp_cnt < 8) begin
      @(negedge clk);
      granted = (p1_ready === 1'b1);
      if (granted && gi < 8) begin
        grant_cyc[gi] = cyc;
        gi++;
      end
      if (p1_rsp_valid === 1'b1) rsp_cnt++;
      if (mem_we_n === 1'b0) low_cnt++;
      next_cycle();
      cyc++;
      if (granted) begin
        idx++;
        if (idx < 8) begin
          p1_addr  = 16'(200 + idx);
          p1_wdata = 16'(200 + idx);
        end else begin
          p1_valid = 1'b0;
        end
      end
    end
    total++;
    if (rsp_cnt != 8 || gi != 8 || low_cnt != 8) begin
      bad++;
      $display("FAIL stream_counts: rsp=%0d grants=%0d we_low=%0d required 8/8/8", rsp_cnt, gi, low_cnt);
    end
    for (int k = 0; k < gi; k++) begin
      total++;
      if (grant_cyc[k] != 2 * k) begin
        bad++;
        $display("FAIL stream_spacing %0d: cycle=%0d required %0d", k, grant_cyc[k], 2 * k);
      end
    end
    for (int k = 0; k < 8; k++) begin
      total++;
      if (written[200 + k] !== 1'b1 || sram[200 + k] !== 16'(200 + k)) begin
        bad++;
        $display("FAIL stream_sram %0d: value=%0d required %0d", 200 + k, sram[200 + k], 200 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    int rsp_seen;
    drop_all();
    next_cycle();
    p0_valid = 1'b1; p0_we_n = 1'b0; p0_addr = 16'd50; p0_wdata = 16'h5555;
    @(negedge clk);
    total++;
    if (p0_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_grant: ready=%b required 1", p0_ready);
    end
    next_cycle();
    p0_valid = 1'b0;
    total++;
    if (mem_we_n !== 1'b0) begin
      bad++;
      $display("FAIL rst_issue: we_n=%b required 0", mem_we_n);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (mem_we_n !== 1'b1) begin
      bad++;
      $display("FAIL rst_async_we: we_n=%b required 1", mem_we_n);
    end
    rsp_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (p0_rsp_valid !== 1'b0) rsp_seen++;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (p0_rsp_valid !== 1'b0) rsp_seen++;
    end
    total++;
    if (rsp_seen != 0) begin
      bad++;
      $display("FAIL rst_no_rsp: %0d response cycles required 0", rsp_seen);
    end
    next_cycle();
    p0_valid = 1'b1; p0_we_n = 1'b1; p0_addr = 16'd300;
    @(negedge clk);
    total++;
    if (p0_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_idle_grant: ready=%b required 1", p0_ready);
    end
    next_cycle();
    p0_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    total++;
    if (p0_rsp_valid !== 1'b1 || p0_rdata !== 16'h00A5) begin
      bad++;
      $display("FAIL rst_after_read: rsp=%b rdata=%h required 1/00a5", p0_rsp_valid, p0_rdata);
    end
    next_cycle();
  endtask

  task automatic test_no_starve();
    int w;
    do_reset();
    p0_valid = 1'b1; p0_we_n = 1'b1; p0_addr = 16'd0;
    p1_valid = 1'b1; p1_we_n = 1'b1; p1_addr = 16'd1;
    @(negedge clk);
    total++;
    if ({p0_ready, p1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL starve_first: p0/p1 ready=%b%b required 10", p0_ready, p1_ready);
    end
    w = 0;
    while (p1_ready !== 1'b1 && w < 6) begin
      next_cycle();
      w++;
      @(negedge clk);
    end
    total++;
    if (p1_ready !== 1'b1 || w > 2) begin
      bad++;
      $display("FAIL starve_p1_wait: waited %0d cycles ready=%b required <=2 and 1", w, p1_ready);
    end
    next_cycle();
    next_cycle();
    @(negedge clk);
    total++;
    if ({p0_ready, p1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL starve_p0_return: p0/p1 ready=%b%b required 10", p0_ready, p1_ready);
    end
    next_cycle();
    drop_all();
    repeat (4) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_both_ports();
    test_stream();
    test_reset_mid();
    test_no_starve();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sram_arbiter
